// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared widths, bit positions and word type for the CPU I/O bridge
package cpu_io_pkg;

    localparam int IO_DATA_W = 14;

    // Bit positions inside the CPU out bus
    localparam int TX_TOG_BIT = 15;
    localparam int RX_ACK_BIT = 14;

    // Bit positions inside the CPU in bus
    localparam int RX_TOG_BIT  = 15;
    localparam int TX_FULL_BIT = 14;

    typedef logic [IO_DATA_W-1:0] io_word_t;

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - synchronous word FIFO with combinational head and async reset
module io_fifo
    import cpu_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  io_word_t push_data,
    input  logic     pop,
    output io_word_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    io_word_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    // Flags come from the pre-edge count, so a push into a full FIFO is refused
    // even when a pop happens on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage, binary pointers (wrap modulo DEPTH) and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// rtl/cpu_io_bridge.sv - CPU word I/O bridge; CPUIO_LOOPBACK_EN adds TX-to-RX loopback
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          cpu_out,
    output logic [15:0]          cpu_in,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [IO_DATA_W-1:0] tx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [IO_DATA_W-1:0] rx_data,
    output logic                 tx_overflow
`ifdef CPUIO_LOOPBACK_EN
    ,
    input  logic                 loopback
`endif
);

    logic [15:0] cpu_out_q;
    logic        tx_tog_seen;
    logic        tx_full_q;
    logic        rx_tog;
    io_word_t    rx_word;

    logic        tx_full;
    logic        tx_empty;
    logic        rx_full;
    logic        rx_empty;
    io_word_t    tx_head;
    io_word_t    rx_head;

    logic        tx_req;
    logic        tx_push;
    logic        tx_pop;
    logic        rx_push;
    logic        rx_present;
    io_word_t    rx_push_data;

    // A new CPU word is announced by a change of the tx toggle bit
    assign tx_req  = (cpu_out_q[TX_TOG_BIT] != tx_tog_seen);
    assign tx_push = tx_req && !tx_full;

    // The CPU has consumed the presented word once its ack matches our toggle
    assign rx_present = (cpu_out_q[RX_ACK_BIT] == rx_tog) && !rx_empty;

`ifdef CPUIO_LOOPBACK_EN
    logic lb_xfer;

    // In loopback the host is disconnected and TX head feeds RX directly
    assign lb_xfer      = loopback && !tx_empty && !rx_full;
    assign tx_valid     = !tx_empty && !loopback;
    assign rx_ready     = !rx_full && !loopback;
    assign tx_pop       = loopback ? lb_xfer : (tx_valid && tx_ready);
    assign rx_push      = loopback ? lb_xfer : (rx_valid && rx_ready);
    assign rx_push_data = loopback ? tx_head : rx_data;
`else
    assign tx_valid     = !tx_empty;
    assign rx_ready     = !rx_full;
    assign tx_pop       = tx_valid && tx_ready;
    assign rx_push      = rx_valid && rx_ready;
    assign rx_push_data = rx_data;
`endif

    assign tx_data                = tx_head;
    assign cpu_in[RX_TOG_BIT]     = rx_tog;
    assign cpu_in[TX_FULL_BIT]    = tx_full_q;
    assign cpu_in[IO_DATA_W-1:0]  = rx_word;

    io_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (cpu_out_q[IO_DATA_W-1:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    io_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_push_data),
        .pop       (rx_present),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Register the CPU out bus and the TX backpressure bit every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_out_q <= '0;
            tx_full_q <= 1'b0;
        end else begin
            cpu_out_q <= cpu_out;
            tx_full_q <= tx_full;
        end
    end

    // Track the tx toggle; a word arriving while TX is full is dropped and flagged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_tog_seen <= 1'b0;
            tx_overflow <= 1'b0;
        end else if (tx_req) begin
            tx_tog_seen <= cpu_out_q[TX_TOG_BIT];
            if (tx_full) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // Present the next RX word to the CPU and flip the rx toggle in the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_tog  <= 1'b0;
            rx_word <= '0;
        end else if (rx_present) begin
            rx_tog  <= ~rx_tog;
            rx_word <= rx_head;
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb/tb_cpu_io_bridge.sv - directed and randomized checks of cpu_io_bridge against a queue model
module tb_cpu_io_bridge;
    import cpu_io_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_out;
    logic [15:0] cpu_in;
    logic        tx_valid;
    logic        tx_ready;
    logic [13:0] tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [13:0] rx_data;
    logic        tx_overflow;
    logic        lb;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: CPU-visible state plus the two FIFOs as queues
    logic [15:0] m_out_q;
    logic [15:0] m_cpu_in;
    logic        m_seen;
    logic        m_ovf;
    logic [13:0] m_txq[$];
    logic [13:0] m_rxq[$];

    logic [13:0] words[5];
    logic [13:0] fill[4];

    always #5 clk = ~clk;

    cpu_io_bridge #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_out     (cpu_out),
        .cpu_in      (cpu_in),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_overflow (tx_overflow)
`ifdef CPUIO_LOOPBACK_EN
        ,
        .loopback    (lb)
`endif
    );

    function automatic void m_clear();
        m_out_q  = '0;
        m_cpu_in = '0;
        m_seen   = 1'b0;
        m_ovf    = 1'b0;
        m_txq.delete();
        m_rxq.delete();
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    function automatic void m_step();
        bit          txf, txe, rxf, rxe, tx_pop, rx_push, present;
        logic [13:0] rx_w;
        logic [13:0] w;
        if (reset) begin
            m_clear();
            return;
        end
        txf = (m_txq.size() == DEPTH);
        txe = (m_txq.size() == 0);
        rxf = (m_rxq.size() == DEPTH);
        rxe = (m_rxq.size() == 0);
        if (lb) begin
            tx_pop  = !txe && !rxf;
            rx_push = tx_pop;
            rx_w    = txe ? 14'h0 : m_txq[0];
        end else begin
            tx_pop  = !txe && tx_ready;
            rx_push = rx_valid && !rxf;
            rx_w    = rx_data;
        end
        present = (m_out_q[14] == m_cpu_in[15]) && !rxe;
        if (tx_pop) void'(m_txq.pop_front());
        if (m_out_q[15] != m_seen) begin
            m_seen = m_out_q[15];
            if (!txf) m_txq.push_back(m_out_q[13:0]);
            else m_ovf = 1'b1;
        end
        if (present) begin
            w = m_rxq.pop_front();
            m_cpu_in[15]   = ~m_cpu_in[15];
            m_cpu_in[13:0] = w;
        end
        if (rx_push) m_rxq.push_back(rx_w);
        m_cpu_in[14] = txf;
        m_out_q = cpu_out;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("m_cpu_in", cpu_in, m_cpu_in);
        check("m_tx_valid", {15'b0, tx_valid}, {15'b0, (m_txq.size() != 0) && !lb});
        check("m_rx_ready", {15'b0, rx_ready}, {15'b0, (m_rxq.size() != DEPTH) && !lb});
        check("m_tx_overflow", {15'b0, tx_overflow}, {15'b0, m_ovf});
        if (m_txq.size() != 0 && !lb) check("m_tx_data", {2'b0, tx_data}, {2'b0, m_txq[0]});
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check_all();
    endtask

    initial begin
        reset    = 1'b1;
        cpu_out  = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        lb       = 1'b0;
        m_clear();
        #1;
        check("rst_cpu_in", cpu_in, 16'h0000);
        check("rst_tx_valid", {15'b0, tx_valid}, 16'h0);
        check("rst_rx_ready", {15'b0, rx_ready}, 16'h1);
        check("rst_tx_overflow", {15'b0, tx_overflow}, 16'h0);
        tick();
        tick();
        reset = 1'b0;

        // Idle with cpu_out=0
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_cpu_in", cpu_in, 16'h0000);
            check("idle_rx_ready", {15'b0, rx_ready}, 16'h1);
        end

        // TX latency: word visible two cycles after the toggle, for one cycle
        tx_ready = 1'b1;
        cpu_out  = 16'h8123;
        tick();
        check("lat_n1_tx_valid", {15'b0, tx_valid}, 16'h0);
        tick();
        check("lat_n2_tx_valid", {15'b0, tx_valid}, 16'h1);
        check("lat_n2_tx_data", {2'b0, tx_data}, 16'h0123);
        tick();
        check("lat_n3_tx_valid", {15'b0, tx_valid}, 16'h0);

        // TX overflow: five words into a four-deep FIFO with the host stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            words[i] = 14'($urandom);
            cpu_out  = {~cpu_out[15], 1'b0, words[i]};
            tick();
        end
        check("ovf_pre_full_bit", {15'b0, cpu_in[14]}, 16'h0);
        check("ovf_pre_overflow", {15'b0, tx_overflow}, 16'h0);
        tick();
        check("ovf_full_bit", {15'b0, cpu_in[14]}, 16'h1);
        check("ovf_overflow", {15'b0, tx_overflow}, 16'h1);
        tick();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_pop_valid", {15'b0, tx_valid}, 16'h1);
            check("ovf_pop_data", {2'b0, tx_data}, {2'b0, words[i]});
            tick();
        end
        check("ovf_drained", {15'b0, tx_valid}, 16'h0);
        check("ovf_sticky", {15'b0, tx_overflow}, 16'h1);
        tx_ready = 1'b0;

        // RX present and hold until acknowledged
        rx_valid = 1'b1;
        rx_data  = 14'h0AAA;
        tick();
        rx_data  = 14'h0555;
        tick();
        rx_valid = 1'b0;
        check("rx_first", cpu_in, 16'h8AAA);
        repeat (5) tick();
        check("rx_hold", cpu_in, 16'h8AAA);
        cpu_out[14] = 1'b1;
        tick();
        check("rx_ack_n1", cpu_in, 16'h8AAA);
        tick();
        check("rx_ack_n2", cpu_in, 16'h0555);

        // Fill RX while the CPU has not acknowledged
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill[i] = 14'($urandom);
            rx_data = fill[i];
            tick();
        end
        check("fill_ready", {15'b0, rx_ready}, 16'h0);
        rx_data = 14'($urandom);
        tick();
        check("fill_ready_hold", {15'b0, rx_ready}, 16'h0);
        check("fill_cpu_hold", cpu_in, 16'h0555);
        cpu_out[14] = 1'b0;
        tick();
        check("fill_ack_n1", {15'b0, rx_ready}, 16'h0);
        tick();
        check("fill_ack_n2", {15'b0, rx_ready}, 16'h1);
        check("fill_present", cpu_in, {2'b10, fill[0]});
        rx_valid = 1'b0;
        tick();

`ifdef CPUIO_LOOPBACK_EN
        // Loopback: CPU word returns to the CPU without reaching the host
        reset = 1'b1;
        m_clear();
        tick();
        reset   = 1'b0;
        cpu_out = 16'h0000;
        tick();
        lb       = 1'b1;
        tx_ready = 1'b1;
        cpu_out  = 16'h9234;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lb_tx_valid", {15'b0, tx_valid}, 16'h0);
        end
        check("lb_cpu_in", cpu_in, 16'h9234);
        lb = 1'b0;
        tick();
`endif

        // Randomized traffic with a reset in the middle
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                reset = 1'b1;
                m_clear();
                #1;
                check("mid_rst_cpu_in", cpu_in, 16'h0000);
                check("mid_rst_tx_valid", {15'b0, tx_valid}, 16'h0);
                check("mid_rst_overflow", {15'b0, tx_overflow}, 16'h0);
                check("mid_rst_rx_ready", {15'b0, rx_ready}, 16'h1);
            end
            if (c == 201) reset = 1'b0;
            if ($urandom_range(0, 2) == 0) cpu_out[15] = ~cpu_out[15];
            if ($urandom_range(0, 2) == 0) cpu_out[14] = ~cpu_out[14];
            cpu_out[13:0] = 14'($urandom);
            tx_ready = (c < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data  = 14'($urandom);
`ifdef CPUIO_LOOPBACK_EN
            if ($urandom_range(0, 15) == 0) lb = ~lb;
`endif
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
